// File: rtl/countdown_timer.sv
// countdown_timer
//   Programmable down-counting timer peripheral. Software loads a start value,
//   the block counts toward zero and raises a sticky interrupt request on
//   expiry, held until acknowledged. One-shot and auto-reload modes, with an
//   optional prescaler that divides enabled clock cycles into count ticks.
//
// Parameters
//   WIDTH    : width of the count, load value and reload register
//   PRESCALE : enabled clk cycles per decrement (>= 1)
//
// Ports
//   clk         in   system clock, rising-edge
//   clr_n       in   asynchronous active-low reset
//   Enable      in   count enable; 0 freezes count and prescaler
//   load        in   one-cycle load strobe (wins over counting)
//   load_val    in   start/reload value, sampled with load
//   auto_reload in   sampled with load; 1 = periodic, 0 = one-shot
//   irq_ack     in   one-cycle acknowledge; clears irq and ovf
//   res         out  current count value (registered)
//   busy        out  1 while counting
//   irq         out  sticky expiry flag
//   ovf         out  sticky: expiry while irq was already pending
module countdown_timer #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             Enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             irq,
  output logic             ovf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO      = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             irq_q, irq_d;
  logic             ovf_q, ovf_d;
  logic             expire;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    irq_d    = irq_q;
    ovf_d    = ovf_q;
    expire   = 1'b0;

    if (load) begin
      reload_d = load_val;
      mode_d   = auto_reload;
      res_d    = load_val;
      presc_d  = '0;
      state_d  = (load_val != ZERO) ? RUN : IDLE;
    end else if (state_q == RUN && Enable) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        // Expiry is detected at 1 so the count never wraps through zero.
        if (res_q > ONE) begin
          res_d = res_q - ONE;
        end else begin
          expire = 1'b1;
          if (mode_q) begin
            res_d = reload_q;
          end else begin
            res_d   = ZERO;
            state_d = DONE;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // Acknowledge clears both flags; a same-cycle expiry then re-asserts irq
    // but is not counted as an overflow because the old request was consumed.
    if (irq_ack) begin
      irq_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (expire) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      presc_q  <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
    end
  end

  assign res  = res_q;
  assign busy = (state_q == RUN);
  assign irq  = irq_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a PRESCALE=1 and a PRESCALE=4 instance
// share one stimulus stream; expected outputs are queued as each step is
// driven and compared once the DUT has taken the following edge.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        en;
  logic        load;
  logic [31:0] load_val;
  logic        auto_reload;
  logic        irq_ack;

  logic [31:0] res1, res4;
  logic        busy1, busy4, irq1, irq4, ovf1, ovf4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    bit          sel;   // 0: PRESCALE=1 instance, 1: PRESCALE=4 instance
    logic [31:0] res;
    logic        busy;
    logic        irq;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(32), .PRESCALE(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .Enable(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .irq_ack(irq_ack),
    .res(res1), .busy(busy1), .irq(irq1), .ovf(ovf1)
  );

  countdown_timer #(.WIDTH(32), .PRESCALE(4)) dut4 (
    .clk(clk), .clr_n(clr_n), .Enable(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .irq_ack(irq_ack),
    .res(res4), .busy(busy4), .irq(irq4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic push(input string tag, input bit sel, input logic [31:0] r,
                      input logic b, input logic i, input logic o);
    exp_t e;
    e.tag = tag; e.sel = sel; e.res = r; e.busy = b; e.irq = i; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [31:0] r;
    logic b, i, o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      r = e.sel ? res4  : res1;
      b = e.sel ? busy4 : busy1;
      i = e.sel ? irq4  : irq1;
      o = e.sel ? ovf4  : ovf1;
      $display("[%0t] %s p%0d res=%0h busy=%0b irq=%0b ovf=%0b",
               $time, e.tag, e.sel ? 4 : 1, r, b, i, o);
      chk(e.tag, "res",  r, e.res);
      chk(e.tag, "busy", {31'b0, b}, {31'b0, e.busy});
      chk(e.tag, "irq",  {31'b0, i}, {31'b0, e.irq});
      chk(e.tag, "ovf",  {31'b0, o}, {31'b0, e.ovf});
    end
  endtask

  task automatic step_check();
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    clr_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
    auto_reload = 1'b0; irq_ack = 1'b0;

    // 1. reset, then one-shot load of 5
    repeat (2) @(posedge clk);
    #1;
    push("reset", 0, 0, 0, 0, 0);
    push("reset", 1, 0, 0, 0, 0);
    check_now();
    clr_n = 1'b1;
    load = 1'b1; load_val = 5; auto_reload = 1'b0; en = 1'b1;
    push("os_load", 0, 5, 1, 0, 0);
    step_check();
    load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push("os_count", 0, 32'(5 - k), k < 5, k == 5, 0);
      step_check();
    end
    for (int k = 0; k < 10; k++) begin
      push("os_done_hold", 0, 0, 0, 1, 0);
      step_check();
    end

    // 2. enable gap
    irq_ack = 1'b1;
    push("ack_done", 0, 0, 0, 0, 0);
    step_check();
    irq_ack = 1'b0;
    load = 1'b1; load_val = 8;
    push("gap_load", 0, 8, 1, 0, 0);
    step_check();
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push("gap_run", 0, 32'(8 - k), 1, 0, 0);
      step_check();
    end
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push("gap_hold", 0, 5, 1, 0, 0);
      step_check();
    end
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push("gap_resume", 0, 32'(5 - k), k < 5, k == 5, 0);
      step_check();
    end

    // 3. auto-reload and overflow (ack with load clears the stale irq)
    load = 1'b1; load_val = 3; auto_reload = 1'b1; irq_ack = 1'b1;
    push("ar_load", 0, 3, 1, 0, 0);
    step_check();
    load = 1'b0; irq_ack = 1'b0;
    push("ar_2", 0, 2, 1, 0, 0); step_check();
    push("ar_1", 0, 1, 1, 0, 0); step_check();
    push("ar_exp1", 0, 3, 1, 1, 0); step_check();
    push("ar_2b", 0, 2, 1, 1, 0); step_check();
    push("ar_1b", 0, 1, 1, 1, 0); step_check();
    push("ar_exp2_ovf", 0, 3, 1, 1, 1); step_check();
    irq_ack = 1'b1;
    push("ar_ack", 0, 2, 1, 0, 0); step_check();
    irq_ack = 1'b0;

    // 4. ack coinciding with expiry
    load = 1'b1; load_val = 2; auto_reload = 1'b1;
    push("sim_load", 0, 2, 1, 0, 0); step_check();
    load = 1'b0;
    push("sim_1", 0, 1, 1, 0, 0); step_check();
    push("sim_exp1", 0, 2, 1, 1, 0); step_check();
    push("sim_1b", 0, 1, 1, 1, 0); step_check();
    irq_ack = 1'b1;
    push("sim_ack_exp", 0, 2, 1, 1, 0); step_check();
    irq_ack = 1'b0;
    push("sim_after", 0, 1, 1, 1, 0); step_check();
    load = 1'b1; load_val = 0; irq_ack = 1'b1;
    push("load0_ack", 0, 0, 0, 0, 0);
    push("load0_ack", 1, 0, 0, 0, 0);
    step_check();
    irq_ack = 1'b0;

    // 5. prescaler instance
    load_val = 2; auto_reload = 1'b0;
    push("ps_load", 1, 2, 1, 0, 0); step_check();
    load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push("ps_count", 1, 32'(2 - k / 4), k < 8, k == 8, 0);
      step_check();
    end

    // 6a. load 0 aborts a running count
    load = 1'b1; load_val = 10; irq_ack = 1'b1;
    push("ab_load", 0, 10, 1, 0, 0); step_check();
    load = 1'b0; irq_ack = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push("ab_run", 0, 32'(10 - k), 1, 0, 0);
      step_check();
    end
    load = 1'b1; load_val = 0;
    push("ab_load0", 0, 0, 0, 0, 0); step_check();

    // 6b. asynchronous reset mid-count
    load_val = 10;
    push("rst_load", 0, 10, 1, 0, 0); step_check();
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push("rst_run", 0, 32'(10 - k), 1, 0, 0);
      step_check();
    end
    #2 clr_n = 1'b0;
    #1;
    push("async_rst", 0, 0, 0, 0, 0);
    push("async_rst", 1, 0, 0, 0, 0);
    check_now();
    #1 clr_n = 1'b1;
    push("post_rst_idle", 0, 0, 0, 0, 0);
    step_check();

    // all-ones load is a legal start value
    load = 1'b1; load_val = 32'hFFFF_FFFF;
    push("max_load", 0, 32'hFFFF_FFFF, 1, 0, 0); step_check();
    load = 1'b0;
    push("max_dec", 0, 32'hFFFF_FFFE, 1, 0, 0); step_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Programmable down-counting timer: the decrementing counterpart of the free-running up `Counter` in the MIPS CPU.
- Software loads a start value; the block counts toward zero and raises a sticky interrupt request on expiry, held until acknowledged.
- Supports one-shot and auto-reload modes, plus an optional prescaler.
- Sits beside the CPU as a timer peripheral and drives the interrupt line.

Parameters:
- WIDTH, 32: width of the count, load value and reload register.
- PRESCALE, 1: number of enabled clk cycles per decrement (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr_n  input  1  asynchronous active-low reset.
- Enable  input  1  count enable; 0 freezes count and prescaler.
- load  input  1  synchronous load strobe, one cycle.
- load_val  input  WIDTH  start/reload value, sampled when load=1.
- auto_reload  input  1  sampled with load; 1 = periodic, 0 = one-shot.
- irq_ack  input  1  one-cycle acknowledge; clears irq and ovf.
- res  output  WIDTH  current count value (registered).
- busy  output  1  1 while in RUN.
- irq  output  1  sticky expiry flag (registered).
- ovf  output  1  sticky: expiry occurred while irq was already set.

Behaviour:
- Reset (clr_n=0, asynchronous): res=0, irq=0, ovf=0, busy=0, state=IDLE, prescaler=0, reload_reg=0, mode_reg=0. Reset mid-count aborts immediately with no irq.
- States:
  - IDLE: not counting.
  - RUN: counting.
  - DONE: one-shot expired, res=0.
- Priority each edge: reset > load > count.
- load=1 (any state, regardless of Enable):
  - reload_reg←load_val, mode_reg←auto_reload, res←load_val, prescaler←0.
  - Next state RUN if load_val≠0, else IDLE.
  - irq/ovf unchanged unless irq_ack is also asserted.
  - Latency: res=load_val visible after the load edge.
- Tick: in RUN with Enable=1, the prescaler increments. When prescaler==PRESCALE-1, a tick occurs and the prescaler←0. With PRESCALE=1, every enabled cycle is a tick.
- Tick with res>1: res←res-1.
- Tick with res==1 (terminal, expiry):
  - mode_reg=0: res←0, state←DONE.
  - mode_reg=1: res←reload_reg, state stays RUN.
  - irq←1 in both modes.
  - If irq was already 1 and irq_ack=0 that cycle: ovf←1.
- Enable=0: res and prescaler hold; no tick. Enable has no effect outside RUN.
- irq_ack=1: irq←0 and ovf←0, except that an expiry in the same cycle wins: irq stays 1 and ovf stays 0.
- DONE holds res=0 until the next load. IDLE and DONE ignore Enable.
- Load during RUN restarts the count with the new value. Load of 0 stops the timer (IDLE, res=0) without raising irq.
- busy = (state==RUN), combinationally decoded from the state register.
- Arithmetic: unsigned WIDTH-bit. res never wraps below 0, because expiry is detected at res==1. Load of all-ones is legal.
- With PRESCALE=1 and Enable held high, load N at edge k gives irq=1 after edge k+N. In auto mode, the period is exactly N cycles between irq-set edges.

Test Plan:
1. Reset, then one-shot load: clr_n=0 for 2 cycles, then load=1, load_val=5, auto_reload=0, Enable=1 -> res 5,4,3,2,1,0. irq=1 after the 5th edge following load; busy=0, state DONE, res stays 0 for 10 more cycles.
2. Enable gap: load 8, Enable=1 for 3 cycles, 0 for 4, then 1 -> res holds 5 during the gap; irq rises 8 enabled cycles after load.
3. Auto-reload and overflow: load 3, auto_reload=1, no ack -> res 3,2,1,3,2,1,3. irq=1 at the first expiry; ovf=1 at the second expiry. irq_ack then clears both on the next edge.
4. Simultaneous ack and expiry: auto_reload=1, load 2, assert irq_ack exactly on the second expiry edge -> irq stays 1 and ovf stays 0.
5. Prescaler (PRESCALE=4 instance): load 2, Enable=1 -> res changes every 4 cycles; irq rises 8 cycles after load.
6. Abort cases:
   - Load 10, then after 3 cycles load 0 -> res=0, busy=0, irq=0.
   - Load 10, then after 3 cycles pulse clr_n=0 asynchronously mid-cycle -> outputs zero immediately, before the next clk edge.
